// File: rtl/wb_watchdog.sv
// Wishbone pipelined pass-through that tracks outstanding requests and kills
// any bus cycle whose slave stops responding for TIMEOUT cycles.
module wb_watchdog #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LGDEPTH = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_mcyc,
    input  logic               i_mstb,
    input  logic               i_mwe,
    input  logic [AW-1:0]      i_maddr,
    input  logic [DW-1:0]      i_mdata,
    input  logic [DW/8-1:0]    i_msel,
    output logic               o_mack,
    output logic               o_mstall,
    output logic               o_merr,
    output logic [DW-1:0]      o_mdata,
    output logic               o_scyc,
    output logic               o_sstb,
    output logic               o_swe,
    output logic [AW-1:0]      o_saddr,
    output logic [DW-1:0]      o_sdata,
    output logic [DW/8-1:0]    o_ssel,
    input  logic               i_sack,
    input  logic               i_sstall,
    input  logic               i_serr,
    input  logic [DW-1:0]      i_sdata,
    output logic [LGDEPTH-1:0] o_outstanding,
    output logic               o_timeout,
    output logic               o_fault
);

    localparam logic [LGDEPTH-1:0] MAXOUT     = {LGDEPTH{1'b1}};
    localparam logic [15:0]        TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]        TIMER_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LGDEPTH-1:0] outstanding;
    logic [LGDEPTH-1:0] outstanding_next;
    logic [15:0]        timer;
    logic [15:0]        timer_next;
    logic               abort_err;
    logic               timeout_pulse;
    logic               fault;

    logic in_abort;
    logic full;
    logic accept;
    logic returned;
    logic spurious;
    logic waiting;
    logic timeout_hit;

    assign in_abort = (state == ABORT);
    assign full     = (outstanding == MAXOUT);

    // Request side is gated off while aborting and while reset is held.
    assign o_scyc   = i_reset_n && !in_abort && i_mcyc;
    assign o_sstb   = i_reset_n && !in_abort && i_mstb && !full;
    assign o_mstall = in_abort || i_sstall || full;
    assign o_swe    = i_mwe;
    assign o_saddr  = i_maddr;
    assign o_sdata  = i_mdata;
    assign o_ssel   = i_msel;
    assign o_mdata  = i_sdata;

    assign accept   = o_scyc && o_sstb && !i_sstall;
    assign returned = !in_abort && (i_sack || i_serr);
    assign spurious = returned && (outstanding == '0) && !accept;

    // An error wins over a simultaneous ack; unmatched returns never reach the master.
    assign o_mack = i_reset_n && returned && i_sack && !i_serr && !spurious;
    assign o_merr = i_reset_n && (abort_err || (returned && i_serr && !spurious));

    assign waiting = (state == BUSY) && i_mcyc
                     && ((i_mstb && o_mstall) || (outstanding != '0))
                     && !accept && !returned;
    assign timeout_hit = waiting && (timer == TIMER_LAST);

    assign o_outstanding = outstanding;
    assign o_timeout     = timeout_pulse;
    assign o_fault       = fault;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        outstanding_next = outstanding;
        timer_next       = '0;

        unique case (state)
            IDLE:    if (i_mcyc) state_next = BUSY;
            BUSY: begin
                if (timeout_hit) begin
                    state_next = ABORT;
                end else if (!i_mcyc) begin
                    state_next = IDLE;
                end
            end
            ABORT:   if (!i_mcyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (!i_mcyc || in_abort || timeout_hit) begin
            outstanding_next = '0;
        end else if (accept && !returned) begin
            outstanding_next = outstanding + LGDEPTH'(1);
        end else if (returned && !accept && (outstanding != '0)) begin
            outstanding_next = outstanding - LGDEPTH'(1);
        end

        if (waiting && !timeout_hit) begin
            timer_next = (timer == TIMER_MAX) ? timer : timer + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            outstanding   <= '0;
            timer         <= '0;
            abort_err     <= 1'b0;
            timeout_pulse <= 1'b0;
            fault         <= 1'b0;
        end else begin
            outstanding   <= outstanding_next;
            timer         <= timer_next;
            abort_err     <= timeout_hit;
            timeout_pulse <= timeout_hit;
            fault         <= fault || spurious || (returned && i_sack && i_serr);
        end
    end

endmodule
